fcs_rx_check: RTL

FCS_RX_CHECK -- requirements
Module: fcs_rx_check

---
 rtl/fcs_rx_check_if.sv | 14 +
 rtl/fcs_rx_check.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fcs_rx_check_if.sv
// Byte-wide AXI-Stream channel used on both sides of the FCS checker.
// The receive side carries no sideband, so tuser is only exposed on the master modport.
interface fcs_rx_check_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/fcs_rx_check.sv
// Strips and checks the Ethernet FCS using a 5-byte holdback; payload byte n leaves as byte n+5 is accepted.
// Input stalls when the holdback is full and the output stalls; in TAIL the input is held off.
module fcs_rx_check #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  fcs_rx_check_if.slave  s_axis,
  fcs_rx_check_if.master m_axis,
  output logic           frame_ok,
  output logic           frame_bad,
  output logic           frame_runt,
  output logic [15:0]    err_count
);

  if (DATA_W != 8) begin : g_width_chk
    $error("fcs_rx_check: DATA_W must be 8");
  end

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] RESIDUE  = 32'hDEBB_20E3;

  typedef enum logic {RUN, TAIL} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] fifo_q [5];
  logic [DATA_W-1:0] fifo_d [5];
  logic [31:0]       crc_q, crc_d, crc_upd;
  logic              fail_q, fail_d;
  logic              ok_q, ok_d, bad_q, bad_d, runt_q, runt_d;
  logic [15:0]       err_q, err_d;
  logic              s_rdy, s_acc, m_vld, m_last, m_user;

  function automatic logic [31:0] crc32_ethernet_byte(input logic [31:0] crc,
                                                      input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  assign crc_upd = crc32_ethernet_byte(crc_q, s_axis.tdata);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fifo_d  = fifo_q;
    crc_d   = crc_q;
    fail_d  = fail_q;
    ok_d    = 1'b0;
    bad_d   = 1'b0;
    runt_d  = 1'b0;
    s_rdy   = 1'b0;
    s_acc   = 1'b0;
    m_vld   = 1'b0;
    m_last  = 1'b0;
    m_user  = 1'b0;

    case (state_q)
      RUN: begin
        // A full holdback can only take a byte if the oldest one leaves this cycle.
        s_rdy = (cnt_q != 3'd5) | m_axis.tready;
        m_vld = (cnt_q == 3'd5) & s_axis.tvalid;
        s_acc = s_axis.tvalid & s_rdy;
        if (s_acc) begin
          crc_d = crc_upd;
          if (cnt_q == 3'd5) begin
            for (int i = 0; i < 4; i++) begin
              fifo_d[i] = fifo_q[i+1];
            end
            fifo_d[4] = s_axis.tdata;
          end else begin
            fifo_d[cnt_q] = s_axis.tdata;
            cnt_d         = cnt_q + 3'd1;
          end
          if (s_axis.tlast) begin
            if (cnt_q >= 3'd4) begin
              state_d = TAIL;
              fail_d  = (crc_upd != RESIDUE);
            end else begin
              runt_d = 1'b1;
              cnt_d  = 3'd0;
              crc_d  = CRC_INIT;
            end
          end
        end
      end
      TAIL: begin
        m_vld  = 1'b1;
        m_last = 1'b1;
        m_user = fail_q;
        if (m_axis.tready) begin
          ok_d    = ~fail_q;
          bad_d   = fail_q;
          cnt_d   = 3'd0;
          crc_d   = CRC_INIT;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    err_d = err_q;
    if ((bad_d | runt_d) && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      crc_q   <= CRC_INIT;
      fail_q  <= 1'b0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
      runt_q  <= 1'b0;
      err_q   <= 16'd0;
      for (int i = 0; i < 5; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      fail_q  <= fail_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
      runt_q  <= runt_d;
      err_q   <= err_d;
      fifo_q  <= fifo_d;
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = m_vld;
  assign m_axis.tdata  = fifo_q[0];
  assign m_axis.tlast  = m_last;
  assign m_axis.tuser  = m_user;

  assign frame_ok   = ok_q;
  assign frame_bad  = bad_q;
  assign frame_runt = runt_q;
  assign err_count  = err_q;

endmodule
